// File: rtl/regfile_dump_if.sv
// Dump stream between the controller and its consumer: one word per handshake,
// plus the consumer's expected value for the word on offer.
interface regfile_dump_if;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic [31:0] exp_data;

  modport master (
    output dump_valid, dump_idx, dump_data,
    input  dump_ready, exp_data
  );

  modport slave (
    input  dump_valid, dump_idx, dump_data,
    output dump_ready, exp_data
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Runs the processor for a fixed number of cycles while tracing regfile writes,
// then hijacks read port A and streams every register out. Optional DUMP_COMPARE_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_RUN    | processor runs, writes to r1..r31 are traced
// S_SETTLE | read port A settles on rs1_test for one cycle
// S_OUT    | dump word offered, waiting for dump_ready
// S_DONE   | all registers dumped, port A still hijacked
module regfile_dump_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int CYC_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CYC_W-1:0]  num_cycles_i,
  input  logic              proc_rwe_i,
  input  logic [4:0]        proc_rd_i,
  input  logic [31:0]       proc_wdata_i,
  output logic              trace_valid_o,
  output logic [CYC_W-1:0]  trace_cycle_o,
  output logic [4:0]        trace_rd_o,
  output logic [31:0]       trace_data_o,
  output logic              test_mode_o,
  output logic [4:0]        rs1_test_o,
  input  logic [31:0]       rega_i,
  regfile_dump_if.master    dump,
  output logic              mismatch_o,
  output logic [5:0]        err_count_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SETTLE, S_OUT, S_DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  ncyc_q, ncyc_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        idx_q, idx_d;
  logic              test_mode_q, test_mode_d;
  logic [4:0]        dump_idx_q, dump_idx_d;
  logic [31:0]       dump_data_q, dump_data_d;
  logic              trace_valid_q, trace_valid_d;
  logic [CYC_W-1:0]  trace_cycle_q, trace_cycle_d;
  logic [4:0]        trace_rd_q, trace_rd_d;
  logic [31:0]       trace_data_q, trace_data_d;
  logic              mismatch_q, mismatch_d;
  logic [5:0]        err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ncyc_q        <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      test_mode_q   <= 1'b0;
      dump_idx_q    <= '0;
      dump_data_q   <= '0;
      trace_valid_q <= 1'b0;
      trace_cycle_q <= '0;
      trace_rd_q    <= '0;
      trace_data_q  <= '0;
      mismatch_q    <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      ncyc_q        <= ncyc_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      test_mode_q   <= test_mode_d;
      dump_idx_q    <= dump_idx_d;
      dump_data_q   <= dump_data_d;
      trace_valid_q <= trace_valid_d;
      trace_cycle_q <= trace_cycle_d;
      trace_rd_q    <= trace_rd_d;
      trace_data_q  <= trace_data_d;
      mismatch_q    <= mismatch_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ncyc_d        = ncyc_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    test_mode_d   = test_mode_q;
    dump_idx_d    = dump_idx_q;
    dump_data_d   = dump_data_q;
    trace_valid_d = 1'b0;
    trace_cycle_d = trace_cycle_q;
    trace_rd_d    = trace_rd_q;
    trace_data_d  = trace_data_q;
    mismatch_d    = 1'b0;
    err_d         = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          ncyc_d      = num_cycles_i;
          cnt_d       = '0;
          idx_d       = '0;
          err_d       = '0;
          // A zero-length run needs port A immediately for the first dump word.
          if (num_cycles_i == '0) begin
            state_d     = S_SETTLE;
            test_mode_d = 1'b1;
          end else begin
            state_d     = S_RUN;
            test_mode_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (proc_rwe_i && (proc_rd_i != 5'd0)) begin
          trace_valid_d = 1'b1;
          trace_cycle_d = cnt_q;
          trace_rd_d    = proc_rd_i;
          trace_data_d  = proc_wdata_i;
        end
        if (cnt_q == ncyc_q - 1'b1) begin
          state_d     = S_SETTLE;
          test_mode_d = 1'b1;
          idx_d       = '0;
        end
      end
      S_SETTLE: begin
        state_d     = S_OUT;
        dump_idx_d  = idx_q;
        dump_data_d = rega_i;
      end
      S_OUT: begin
        if (dump.dump_ready) begin
`ifdef DUMP_COMPARE_EN
          if (dump_data_q != dump.exp_data) begin
            mismatch_d = 1'b1;
            if (err_q != 6'd63) err_d = err_q + 6'd1;
          end
`endif
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_SETTLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dump.dump_valid = (state_q == S_OUT);
  assign dump.dump_idx   = dump_idx_q;
  assign dump.dump_data  = dump_data_q;

  assign trace_valid_o = trace_valid_q;
  assign trace_cycle_o = trace_cycle_q;
  assign trace_rd_o    = trace_rd_q;
  assign trace_data_o  = trace_data_q;
  assign test_mode_o   = test_mode_q;
  assign rs1_test_o    = idx_q;
  assign mismatch_o    = mismatch_q;
  assign err_count_o   = err_q;
  assign busy_o        = (state_q == S_RUN) || (state_q == S_SETTLE) || (state_q == S_OUT);
  assign done_o        = (state_q == S_DONE);

endmodule

// File: doc/regfile_dump_ctrl.md
REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, the number of registers dumped (2..32).
REQ-002 SHALL have parameter CYC_W, default 8, the width of the run-cycle counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; clears all state.
REQ-006 start  in  1  request to begin a run; ignored unless state is IDLE or DONE.
REQ-007 num_cycles  in  CYC_W  run length, sampled on the accepted start.
REQ-008 proc_rwe  in  1  processor regfile write enable (monitored).
REQ-009 proc_rd  in  5  processor regfile write address (monitored).
REQ-010 proc_wdata  in  32  processor regfile write data (monitored).
REQ-011 trace_valid  out  1  one-cycle pulse: a traced write occurred.
REQ-012 trace_cycle / trace_rd / trace_data  out  CYC_W/5/32  cycle index, register and data of the traced write.
REQ-013 test_mode  out  1  high: the regfile read port A is hijacked by rs1_test.
REQ-014 rs1_test  out  5  register index driven onto read port A.
REQ-015 regA  in  32  regfile read port A data.
REQ-016 dump_valid  out  1  dump word available; dump_ready  in  1  consumer accepts.
REQ-017 dump_idx / dump_data  out  5/32  index and value of the dumped register.
REQ-018 exp_data  in  32  expected value for dump_idx (used only with the compare feature).
REQ-019 mismatch  out  1  dumped value differs from exp_data; err_count  out  6  mismatch total.
REQ-020 busy / done  out  1/1  run or dump in progress / dump complete.

Function
REQ-021 The block SHALL implement the states IDLE, RUN, SETTLE, OUT and DONE.
REQ-022 IDLE/DONE: on start, latch num_cycles, clear the cycle count, idx, err_count and test_mode, and go to RUN; if num_cycles==0, go directly to SETTLE instead.
REQ-023 RUN: increment the cycle count each clock; on the clock where count==num_cycles-1, go to SETTLE and set test_mode=1 and rs1_test=0.
REQ-024 RUN: when proc_rwe=1 and proc_rd!=0, assert trace_valid on the next cycle for exactly one cycle, carrying that cycle's count, rd and data; writes to r0 and writes outside RUN SHALL NOT be traced.
REQ-025 SETTLE: lasts exactly one cycle, then go to OUT, register dump_data=regA and dump_idx=rs1_test, and assert dump_valid.
REQ-026 OUT: hold dump_valid, dump_idx and dump_data stable until dump_ready=1; on that handshake, go to DONE if idx==NUM_REGS-1, otherwise increment idx/rs1_test and go to SETTLE.
REQ-027 DONE: assert done=1 and keep test_mode=1 until the next accepted start.
REQ-028 busy=1 in RUN, SETTLE and OUT; start during busy SHALL be ignored.
REQ-029 Latency: with dump_ready tied high, done SHALL rise num_cycles+2*NUM_REGS cycles after the accepted start.
REQ-030 The cycle count SHALL NOT wrap; num_cycles=2^CYC_W-1 gives a full-length run.

Reset
REQ-031 When reset is low, the block SHALL asynchronously enter IDLE and drive every output to 0 (test_mode=0, rs1_test=0, dump_valid=0, trace_valid=0, err_count=0, busy=0, done=0).
REQ-032 Reset asserted mid-RUN or mid-dump SHALL abort without emitting a further dump_valid or trace_valid; a new start is required after release.

Configuration
REQ-033 Macro DUMP_COMPARE_EN: when defined, exp_data SHALL be compared on each OUT handshake; mismatch SHALL pulse for one cycle after a differing handshake, and err_count SHALL increment, saturating at 63.
REQ-034 Without DUMP_COMPARE_EN: exp_data SHALL be ignored and mismatch and err_count SHALL be held at 0.

Verification
REQ-035 num_cycles=10, dump_ready=1, NUM_REGS=32 -> done rises 74 cycles after start, with 32 dump words at idx 0..31 in order.
REQ-036 proc_rwe=1, rd=5, data=0x2A at run cycle 3, plus rd=0 at cycle 4 -> exactly one trace_valid pulse with cycle=3, rd=5, data=42.
REQ-037 dump_ready low for 5 cycles at idx 7 -> dump_valid, dump_idx=7 and dump_data held stable, then idx 8 follows after 2 cycles.
REQ-038 DUMP_COMPARE_EN defined, exp_data mismatches at idx 3 and idx 9 -> two mismatch pulses and err_count=2 at done.
REQ-039 reset pulsed low at idx 12 -> all outputs 0 at once and no dump_valid; a later start with num_cycles=0 -> SETTLE next cycle, dump idx 0 follows.
REQ-040 start pulsed during OUT -> ignored, dump completes normally; start in DONE -> test_mode drops and RUN restarts.
